// File: rtl/mem_pkg.sv
// Shared definitions for the eight-word register bank.
//   MEM_ADDR_W / MEM_DEPTH / MEM_DATA_W : bank geometry
//   mem_word_t  : one stored word
//   mem_req_t   : request fields sampled on accept
//   rsp_state_t : response-slot occupancy (EMPTY / FULL)
//   onehot_dec  : 1-of-8 write-enable decode of a word address
package mem_pkg;

    localparam int MEM_ADDR_W = 3;
    localparam int MEM_DEPTH  = 8;
    localparam int MEM_DATA_W = 16;

    typedef logic [MEM_DATA_W-1:0] mem_word_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        mem_word_t             wdata;
    } mem_req_t;

    typedef enum logic [0:0] {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

    function automatic logic [MEM_DEPTH-1:0] onehot_dec(input logic [MEM_ADDR_W-1:0] addr);
        logic [MEM_DEPTH-1:0] dec;
        dec = {{(MEM_DEPTH-1){1'b0}}, 1'b1} << addr;
        return dec;
    endfunction

endpackage

// File: rtl/mem_word_reg.sv
// One storage word of the bank.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; loads RST_VALUE
//   load  : capture d at the next edge
//   d     : data to store
//   q     : stored word
module mem_word_reg
    import mem_pkg::*;
#(
    parameter int                DATA_W    = MEM_DATA_W,
    parameter logic [DATA_W-1:0] RST_VALUE = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] word_d;
    logic [DATA_W-1:0] word_q;

    // Next word value: new data when loaded, otherwise hold.
    always_comb begin
        word_d = word_q;
        if (load) begin
            word_d = d;
        end else begin
            word_d = word_q;
        end
    end

    // Word storage register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= RST_VALUE;
        end else begin
            word_q <= word_d;
        end
    end

    assign q = word_q;

endmodule

// File: rtl/ram8_access_ctrl.sv
// Eight-word register bank behind a valid/ready request/response interface.
// One response slot; responses are registered one cycle after accept.
//   clk, reset              : clock, asynchronous active-high reset
//   req_valid/req_ready     : request handshake
//   req_we/req_addr/req_wdata : request fields (sampled on accept only)
//   rsp_valid/rsp_ready     : response handshake
//   rsp_rdata               : read data, or echoed write data
//   rsp_was_wr              : response belongs to a write
// Optional feature macro ACCESS_COUNT_EN adds:
//   cnt_clr  : synchronous clear of both counters (wins over an accept)
//   rd_count : saturating count of accepted reads
//   wr_count : saturating count of accepted writes
module ram8_access_ctrl
    import mem_pkg::*;
#(
    parameter int                DATA_W    = MEM_DATA_W,
    parameter logic [DATA_W-1:0] RST_VALUE = {DATA_W{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [MEM_ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
`ifdef ACCESS_COUNT_EN
    input  logic                  cnt_clr,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count,
`endif
    output logic                  rsp_was_wr
);

    mem_req_t             req_s;
    logic                 accept_s;
    logic                 wr_accept_s;
    logic [MEM_DEPTH-1:0] load_en_s;
    logic [DATA_W-1:0]    word_q [MEM_DEPTH];

    rsp_state_t           state_d,  state_q;
    logic [DATA_W-1:0]    rdata_d,  rdata_q;
    logic                 was_wr_d, was_wr_q;

    assign req_s.we    = req_we;
    assign req_s.addr  = req_addr;
    assign req_s.wdata = req_wdata;

    assign rsp_valid   = (state_q == RSP_FULL);
    assign req_ready   = !rsp_valid || rsp_ready;
    assign accept_s    = req_valid && req_ready;
    assign wr_accept_s = accept_s && req_s.we;
    assign load_en_s   = wr_accept_s ? onehot_dec(req_s.addr) : {MEM_DEPTH{1'b0}};

    genvar gi;
    generate
        for (gi = 0; gi < MEM_DEPTH; gi++) begin : g_word
            mem_word_reg #(
                .DATA_W    (DATA_W),
                .RST_VALUE (RST_VALUE)
            ) u_word (
                .clk   (clk),
                .reset (reset),
                .load  (load_en_s[gi]),
                .d     (req_s.wdata),
                .q     (word_q[gi])
            );
        end
    endgenerate

    // Response-slot next state: filled on accept, drained on consume.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RSP_EMPTY: begin
                if (accept_s) begin
                    state_d = RSP_FULL;
                end else begin
                    state_d = RSP_EMPTY;
                end
            end
            RSP_FULL: begin
                // Consume and accept in one cycle keeps the slot full.
                if (accept_s) begin
                    state_d = RSP_FULL;
                end else if (rsp_ready) begin
                    state_d = RSP_EMPTY;
                end else begin
                    state_d = RSP_FULL;
                end
            end
            default: begin
                state_d = RSP_EMPTY;
            end
        endcase
    end

    // Response payload: loaded only on accept so it holds under backpressure.
    // The read path sees the word as committed at earlier edges.
    always_comb begin
        rdata_d  = rdata_q;
        was_wr_d = was_wr_q;
        if (accept_s) begin
            rdata_d  = req_s.we ? req_s.wdata : word_q[req_s.addr];
            was_wr_d = req_s.we;
        end else begin
            rdata_d  = rdata_q;
            was_wr_d = was_wr_q;
        end
    end

    // Response slot registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RSP_EMPTY;
            rdata_q  <= RST_VALUE;
            was_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            was_wr_q <= was_wr_d;
        end
    end

    assign rsp_rdata  = rdata_q;
    assign rsp_was_wr = was_wr_q;

`ifdef ACCESS_COUNT_EN
    logic [15:0] rd_count_d, rd_count_q;
    logic [15:0] wr_count_d, wr_count_q;

    // Saturating access counters; clear has priority over counting.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (cnt_clr) begin
            rd_count_d = 16'h0000;
            wr_count_d = 16'h0000;
        end else if (accept_s) begin
            if (req_s.we) begin
                if (wr_count_q != 16'hFFFF) begin
                    wr_count_d = wr_count_q + 16'h0001;
                end else begin
                    wr_count_d = wr_count_q;
                end
            end else begin
                if (rd_count_q != 16'hFFFF) begin
                    rd_count_d = rd_count_q + 16'h0001;
                end else begin
                    rd_count_d = rd_count_q;
                end
            end
        end else begin
            rd_count_d = rd_count_q;
            wr_count_d = wr_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count_q <= 16'h0000;
            wr_count_q <= 16'h0000;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_ram8_access_ctrl.sv
// Scoreboard bench for ram8_access_ctrl. Expected responses are pushed when a
// request is accepted (per the bench's own memory/handshake model) and popped
// when the response is consumed.
module tb_ram8_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_was_wr;
`ifdef ACCESS_COUNT_EN
    logic        cnt_clr;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic [15:0] rd_cnt_m;
    logic [15:0] wr_cnt_m;
`endif

    int vectors;
    int miscompares;

    logic [15:0] mem_m [8];
    logic        full_m;
    logic [16:0] exp_q [$];   // {was_wr, data}

    ram8_access_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
`ifdef ACCESS_COUNT_EN
        .cnt_clr    (cnt_clr),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
`endif
        .rsp_was_wr (rsp_was_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mem_m[i] = 16'h0000;
        full_m = 1'b0;
        exp_q.delete();
`ifdef ACCESS_COUNT_EN
        rd_cnt_m = 16'h0000;
        wr_cnt_m = 16'h0000;
`endif
    endtask

    // Check outputs before the coming edge, update the model, advance one cycle.
    task automatic step(input bit quiet);
        logic        exp_ready;
        logic        acc;
        logic [16:0] head;
        #1;
        exp_ready = !full_m || rsp_ready;
        acc       = req_valid && exp_ready;
        if (!quiet) begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, full_m});
        end
        if (full_m) begin
            head = (exp_q.size() > 0) ? exp_q[0] : 17'h1_DEAD;
            if (!quiet || rsp_ready)
                chk("rsp_payload", {15'd0, rsp_was_wr, rsp_rdata}, {15'd0, head});
            if (rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        end
`ifdef ACCESS_COUNT_EN
        if (!quiet) begin
            chk("rd_count", {16'd0, rd_count}, {16'd0, rd_cnt_m});
            chk("wr_count", {16'd0, wr_count}, {16'd0, wr_cnt_m});
        end
        if (cnt_clr) begin
            rd_cnt_m = 16'h0000;
            wr_cnt_m = 16'h0000;
        end else if (acc) begin
            if (req_we && wr_cnt_m != 16'hFFFF) wr_cnt_m = wr_cnt_m + 16'h0001;
            if (!req_we && rd_cnt_m != 16'hFFFF) rd_cnt_m = rd_cnt_m + 16'h0001;
        end
`endif
        if (acc) begin
            if (req_we) begin
                mem_m[req_addr] = req_wdata;
                exp_q.push_back({1'b1, req_wdata});
            end else begin
                exp_q.push_back({1'b0, mem_m[req_addr]});
            end
        end
        full_m = acc || (full_m && !rsp_ready);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] a,
                         input logic [15:0] wd, input logic rr);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        rsp_ready = rr;
        step(1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 3'd0; req_wdata = 16'h0000;
        rsp_ready = 1'b1;
`ifdef ACCESS_COUNT_EN
        cnt_clr = 1'b0;
`endif
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("rst_was_wr", {31'd0, rsp_was_wr}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1: read after reset
        drive(1'b1, 1'b0, 3'd5, 16'h0000, 1'b1);
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1);

        // 2: write BEEF to 3, read 3, read 2
        drive(1'b1, 1'b1, 3'd3, 16'hBEEF, 1'b1);
        drive(1'b1, 1'b0, 3'd3, 16'h0000, 1'b1);
        drive(1'b1, 1'b0, 3'd2, 16'h0000, 1'b1);
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1);

        // 3: read 3 then hold backpressure for 4 cycles with a new request pending
        drive(1'b1, 1'b0, 3'd3, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 3'd3, 16'h5555, 1'b0);
        drive(1'b1, 1'b1, 3'd6, 16'h0F0F, 1'b1);
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1);

        // 4: back-to-back write 7 then read 7, then sweep every word
        drive(1'b1, 1'b1, 3'd7, 16'h1234, 1'b1);
        drive(1'b1, 1'b0, 3'd7, 16'h0000, 1'b1);
        for (int a = 0; a < 8; a++) drive(1'b1, 1'b0, 3'(a), 16'hFFFF, 1'b1);
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1);

        // 5: reset while a write response is pending
        drive(1'b1, 1'b1, 3'd0, 16'hA5A5, 1'b0);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
        drive(1'b1, 1'b0, 3'd3, 16'h0000, 1'b1);
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1);

`ifdef ACCESS_COUNT_EN
        // 6: counters, clear priority, read saturation
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 3'(i), 16'(i + 16'h0100), 1'b1);
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 3'(i), 16'h0000, 1'b1);
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1);
        chk("wr_count_3", {16'd0, wr_count}, 32'd3);
        chk("rd_count_2", {16'd0, rd_count}, 32'd2);
        cnt_clr = 1'b1;
        drive(1'b1, 1'b1, 3'd4, 16'h4444, 1'b1);
        cnt_clr = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1);
        chk("clr_wr", {16'd0, wr_count}, 32'd0);
        chk("clr_rd", {16'd0, rd_count}, 32'd0);
        req_valid = 1'b1; req_we = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            req_addr = 3'(i);
            step(1'b1);
        end
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1);
        chk("rd_count_sat", {16'd0, rd_count}, 32'h0000_FFFF);
`endif

        if (exp_q.size() != 0)
            chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
